// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, types, S-box and round-constant helpers
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic {
        IDLE,
        EXPAND
    } kx_state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Indices outside 1..10 yield zero so the last-round lookahead stays harmless.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'd10) begin
            return RCON[r];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - 32-bit SubWord through four parallel S-box lookups
module aes_sub_word (
    input  logic [31:0] data,
    output logic [31:0] subbed
);
    import aes_pkg::*;

    always_comb begin
        subbed = '0;
        for (int i = 0; i < 4; i++) begin
            subbed[8*i +: 8] = sbox(data[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - sequential AES-128 key schedule with streamed output and key buffer
module aes_key_expander #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_index,
    output logic [127:0] round_key,
    output logic         done,
    output logic         keys_ready,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);
    import aes_pkg::*;

    localparam logic [3:0] LAST = 4'(NR);

    kx_state_e state;
    kx_state_e state_next;

    state_t     cur;
    logic [3:0] idx;
    logic       ready;
    state_t     keybuf [0:NR];

    logic load;
    logic step;
    logic finish;

    word_t  w0, w1, w2, w3;
    word_t  n0, n1, n2, n3;
    word_t  rot_w3;
    word_t  sub_w3;
    word_t  t;
    state_t next_key;

    assign {w0, w1, w2, w3} = cur;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    aes_sub_word u_sub_word (
        .data   (rot_w3),
        .subbed (sub_w3)
    );

    // Critical path: one SubWord followed by the four-deep XOR ripple.
    always_comb begin
        t        = sub_w3 ^ {rcon(idx + 4'd1), 24'h0};
        n0       = w0 ^ t;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                if (idx == LAST) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= '0;
            idx   <= '0;
            ready <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                keybuf[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (load) begin
                cur       <= key_in;
                idx       <= '0;
                ready     <= 1'b0;
                keybuf[0] <= key_in;
            end else if (step) begin
                cur                 <= next_key;
                idx                 <= idx + 4'd1;
                keybuf[idx + 4'd1]  <= next_key;
            end else if (finish) begin
                ready <= 1'b1;
            end
        end
    end

    assign busy       = (state == EXPAND);
    assign rk_valid   = busy;
    assign rk_index   = idx;
    assign round_key  = cur;
    assign done       = rk_valid && (idx == LAST);
    assign keys_ready = ready;
    assign rd_key     = (rd_idx <= LAST) ? keybuf[rd_idx] : '0;

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - self-checking bench for aes_key_expander
module tb_aes_key_expander;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0]   rd_idx = '0;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_index;
    logic [127:0] round_key;
    logic         done;
    logic         keys_ready;
    logic [127:0] rd_key;

    aes_key_expander #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_index   (rk_index),
        .round_key  (round_key),
        .done       (done),
        .keys_ready (keys_ready),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // S-box and round constants derived from GF(2^8) arithmetic, not copied from a table.
    logic [7:0] sb [0:255];
    logic [7:0] rc [1:10];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    initial begin
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc[1] = 8'h01;
        for (int i = 2; i <= 10; i++) rc[i] = xt(rc[i-1]);
    end

    // Word-wise FIPS-197 key expansion over the full 44-word schedule.
    function automatic logic [127:0] sched_key(input logic [127:0] k, input int r);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Protocol model: one key per cycle after acceptance, idle one cycle after the last key.
    logic [127:0] m_sched [0:10];
    logic [127:0] m_buf   [0:10];
    bit           m_busy = 1'b0;
    int           m_k = 0;
    bit           m_ready = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_k     = 0;
            m_ready = 1'b0;
            for (int i = 0; i <= 10; i++) begin
                m_sched[i] = '0;
                m_buf[i]   = '0;
            end
        end else if (!m_busy) begin
            if (start) begin
                for (int r = 0; r <= 10; r++) m_sched[r] = sched_key(key_in, r);
                m_busy   = 1'b1;
                m_k      = 0;
                m_ready  = 1'b0;
                m_buf[0] = m_sched[0];
            end
        end else if (m_k < 10) begin
            m_k        = m_k + 1;
            m_buf[m_k] = m_sched[m_k];
        end else begin
            m_busy  = 1'b0;
            m_ready = 1'b1;
        end
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic [127:0] stream [0:10];
    int           key0_cyc [$];
    int           done_cyc = -1;
    int           busy_cnt = 0;
    int           valid_cnt = 0;

    initial forever begin
        logic [127:0] exp_rd;
        @(negedge clk);
        exp_rd = (rd_idx <= 4'd10) ? m_buf[rd_idx] : '0;
        chk("busy", busy, m_busy);
        chk("rk_valid", rk_valid, m_busy);
        chk("rk_index", rk_index, m_k);
        chk("round_key", round_key, m_sched[m_k]);
        chk("done", done, m_busy && m_k == 10);
        chk("keys_ready", keys_ready, m_ready);
        chk("rd_key", rd_key, exp_rd);
        if (busy) busy_cnt++;
        if (rk_valid) begin
            valid_cnt++;
            stream[rk_index] = round_key;
            if (rk_index == 4'd0) key0_cyc.push_back(cyc);
            if (done) done_cyc = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic pulse_start(input logic [127:0] k, output int e);
        key_in = k;
        start  = 1'b1;
        @(posedge clk);
        #1;
        e     = cyc;
        start = 1'b0;
    endtask

    task automatic sweep(input bit expect_zero);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 rd_idx = 4'(i);
            #1;
            if (expect_zero || i > 10) chk($sformatf("sweep_%0d", i), rd_key, 128'h0);
            else                       chk($sformatf("sweep_%0d", i), rd_key, stream[i]);
        end
        rd_idx = '0;
    endtask

    initial begin
        int e;
        int n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_rk_valid", rk_valid, 1'b0);
        chk("rst_rk_index", rk_index, 4'd0);
        chk("rst_round_key", round_key, 128'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_keys_ready", keys_ready, 1'b0);
        chk("rst_rd_key", rd_key, 128'h0);
        rst_n = 1'b1;

        chk("model_fips_k1", sched_key(FIPS_KEY, 1), FIPS_K1);
        chk("model_fips_k10", sched_key(FIPS_KEY, 10), FIPS_K10);
        chk("model_zero_k1", sched_key(128'h0, 1), ZERO_K1);
        chk("model_zero_k10", sched_key(128'h0, 10), ZERO_K10);

        // FIPS-197 key, single start pulse
        @(posedge clk);
        #1;
        busy_cnt = 0;
        key0_cyc.delete();
        pulse_start(FIPS_KEY, e);
        wait_idle();
        chk("fips_k0", stream[0], FIPS_KEY);
        chk("fips_k1", stream[1], FIPS_K1);
        chk("fips_k10", stream[10], FIPS_K10);
        chk("fips_done_offset", 32'(done_cyc - e), 32'd10);
        chk("fips_key0_offset", 32'((key0_cyc.size() > 0) ? key0_cyc[0] - e : -1), 32'd0);
        chk("fips_busy_cycles", 32'(busy_cnt), 32'd11);
        chk("fips_keys_ready", keys_ready, 1'b1);
        sweep(1'b0);
        chk("sweep_keys_ready", keys_ready, 1'b1);

        // All-zero key
        pulse_start(128'h0, e);
        wait_idle();
        chk("zero_k0", stream[0], 128'h0);
        chk("zero_k1", stream[1], ZERO_K1);
        chk("zero_k10", stream[10], ZERO_K10);

        // start held high; key_in disturbed mid-run and restored before the restart edge
        @(posedge clk);
        #1;
        busy_cnt = 0;
        key0_cyc.delete();
        key_in = FIPS_KEY;
        start  = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        repeat (3) @(posedge clk);
        #1 key_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        repeat (5) @(posedge clk);
        #1 key_in = FIPS_KEY;
        repeat (16) @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        chk("held_key0_count", 32'(key0_cyc.size()), 32'd3);
        chk("held_key0_a", 32'((key0_cyc.size() > 0) ? key0_cyc[0] - e : -1), 32'd0);
        chk("held_key0_b", 32'((key0_cyc.size() > 1) ? key0_cyc[1] - e : -1), 32'd12);
        chk("held_key0_c", 32'((key0_cyc.size() > 2) ? key0_cyc[2] - e : -1), 32'd24);
        chk("held_busy_cycles", 32'(busy_cnt), 32'd33);
        chk("held_k10", stream[10], FIPS_K10);

        // Reset asserted mid-expansion
        pulse_start(FIPS_KEY, e);
        n = 0;
        while (rk_index != 4'd5 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_reach_idx5", rk_index, 4'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_rk_valid", rk_valid, 1'b0);
        chk("abort_rk_index", rk_index, 4'd0);
        chk("abort_round_key", round_key, 128'h0);
        chk("abort_done", done, 1'b0);
        chk("abort_keys_ready", keys_ready, 1'b0);
        sweep(1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        valid_cnt = 0;
        repeat (15) @(posedge clk);
        #1;
        chk("post_rst_no_emit", 32'(valid_cnt), 32'd0);
        chk("post_rst_keys_ready", keys_ready, 1'b0);

        pulse_start(FIPS_KEY, e);
        wait_idle();
        chk("recover_k10", stream[10], FIPS_K10);
        chk("recover_keys_ready", keys_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
